rgb_to_colour: RTL and testbench

Reverse colour lookup: takes a 24-bit RGB code and returns the 3-bit colour index whose table entry matches it. This is the decoding counterpart of the colour-to-RGB converter. It scans the 8-entry colour table one entry per cycle under a valid/ready handshake on both the request and result sides. It sits downstream of any RGB source (pixel stream, test pattern) that needs to be classified back to a colour code.

---
 rtl/colour_pkg.sv | 23 ++
 rtl/rgb_distance.sv | 30 +++
 rtl/rgb_to_colour.sv | 108 ++++++++++
 tb/tb_rgb_to_colour.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/colour_pkg.sv
// colour_pkg: shared colour constants, RGB table, state type and channel helper.
// Used by the RGB-to-colour decoder and the colour-to-RGB converter ROM init.
package colour_pkg;
    localparam int COLOUR_W  = 3;
    localparam int RGB_W     = 24;
    localparam int N_COLOURS = 8;

    typedef enum logic [COLOUR_W-1:0] {
        BLACK, BLUE, GREEN, CYAN, RED, MAGENTA, YELLOW, WHITE
    } colour_e;

    // Index bits map to channels: [2]=R, [1]=G, [0]=B.
    localparam logic [RGB_W-1:0] RGB_TABLE [N_COLOURS] = '{
        24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
        24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF
    };

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    function automatic logic [7:0] abs_diff(input logic [7:0] x, input logic [7:0] y);
        return x > y ? x - y : y - x;
    endfunction
endpackage

// File: rtl/rgb_distance.sv
// rgb_distance: combinational per-channel comparison of two RGB codes.
// Ports: a, b - RGB codes {R,G,B}; hit - every |channel diff| <= TOL;
//        dist - sum of channel diffs (present only with NEAREST_MATCH_EN).
module rgb_distance
    import colour_pkg::*;
#(
    parameter logic [7:0] TOL = 8'd0
) (
    input  logic [RGB_W-1:0] a,
    input  logic [RGB_W-1:0] b,
    output logic             hit
`ifdef NEAREST_MATCH_EN
    ,
    output logic [9:0]       dist
`endif
);
    logic [7:0] dr, dg, db;

    always_comb begin
        dr  = abs_diff(a[23:16], b[23:16]);
        dg  = abs_diff(a[15:8], b[15:8]);
        db  = abs_diff(a[7:0], b[7:0]);
        hit = dr <= TOL && dg <= TOL && db <= TOL;
    end

`ifdef NEAREST_MATCH_EN
    // Three 8-bit terms sum to at most 765, so 10 bits never overflow.
    assign dist = 10'(dr) + 10'(dg) + 10'(db);
`endif
endmodule

// File: rtl/rgb_to_colour.sv
// rgb_to_colour: reverse colour lookup, scans the 8-entry table one entry per cycle.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/rgb_in request side;
//        result_valid/result_ready/colour/match result side.
// Macro NEAREST_MATCH_EN: on a miss report the nearest entry instead of 0.
module rgb_to_colour
    import colour_pkg::*;
#(
    parameter int unsigned TOL = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [RGB_W-1:0]    rgb_in,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [COLOUR_W-1:0] colour,
    output logic                match
);
    state_e              state, state_next;
    logic [COLOUR_W-1:0] idx, miss_colour;
    logic [RGB_W-1:0]    rgb_q;
    logic                hit, last;

    assign last = idx == COLOUR_W'(N_COLOURS - 1);

`ifdef NEAREST_MATCH_EN
    logic [9:0]          dist, best_dist;
    logic [COLOUR_W-1:0] best_idx;
    logic                closer;

    rgb_distance #(.TOL(8'(TOL))) u_dist (
        .a    (rgb_q),
        .b    (RGB_TABLE[idx]),
        .hit  (hit),
        .dist (dist)
    );

    // Strictly-less update keeps the lowest index on ties.
    assign closer      = dist < best_dist;
    assign miss_colour = closer ? idx : best_idx;

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            best_dist <= '1;
            best_idx  <= '0;
        end else if (state == SCAN && closer) begin
            best_dist <= dist;
            best_idx  <= idx;
        end
    end
`else
    rgb_distance #(.TOL(8'(TOL))) u_dist (
        .a   (rgb_q),
        .b   (RGB_TABLE[idx]),
        .hit (hit)
    );

    assign miss_colour = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = SCAN;
            SCAN:    if (hit || last) state_next = DONE;
            DONE:    if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = rst_n && state == IDLE;
        result_valid = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            colour <= '0;
            match  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    rgb_q <= rgb_in;
                    idx   <= '0;
                end
                SCAN: if (hit) begin
                    colour <= idx;
                    match  <= 1'b1;
                end else if (last) begin
                    colour <= miss_colour;
                    match  <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_to_colour.sv
// tb_rgb_to_colour: directed checks of two lookups sharing stimulus (TOL=0 and TOL=16).
module tb_rgb_to_colour;
`ifdef NEAREST_MATCH_EN
    localparam bit NEAR = 1'b1;
`else
    localparam bit NEAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        result_ready = 1'b0;
    logic [23:0] rgb_in = '0;
    logic        rr0, rv0, m0, rr16, rv16, m16;
    logic [2:0]  c0, c16;
    int          checks = 0;
    int          failures = 0;
    int          l0, l16, seen;
    logic [23:0] tbl [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                             24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

    always #5 clk = ~clk;

    rgb_to_colour #(.TOL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr0), .rgb_in(rgb_in),
        .result_valid(rv0), .result_ready(result_ready), .colour(c0), .match(m0)
    );

    rgb_to_colour #(.TOL(16)) u16 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr16), .rgb_in(rgb_in),
        .result_valid(rv16), .result_ready(result_ready), .colour(c16), .match(m16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request, then record the cycle count after acceptance at which
    // each instance raises result_valid (-1 if it never does within the bound).
    task automatic run(input logic [23:0] rgb);
        @(negedge clk);
        rgb_in = rgb;
        req_valid = 1'b1;
        check("req_ready_before_accept", rr0, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        l0 = -1;
        l16 = -1;
        for (int n = 1; n <= 20 && (l0 < 0 || l16 < 0); n++) begin
            @(posedge clk);
            @(negedge clk);
            if (rv0 && l0 < 0) l0 = n;
            if (rv16 && l16 < 0) l16 = n;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check("rv0_after_handoff", rv0, 0);
        check("rv16_after_handoff", rv16, 0);
        check("req_ready_after_handoff", rr0, 1);
    endtask

    initial begin
        req_valid = 1'b1;
        rgb_in = 24'hFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", rr0, 0);
        check("rst_result_valid", rv0, 0);
        check("rst_colour", c0, 0);
        check("rst_match", m0, 0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("req_ready_after_release", rr0, 1);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i]);
            check("hit_colour", c0, i);
            check("hit_match", m0, 1);
            check("hit_latency", l0, i + 1);
            check("hit_colour_tol16", c16, i);
            check("hit_latency_tol16", l16, i + 1);
            handoff();
        end

        run(24'h123456);
        check("miss_colour", c0, 0);
        check("miss_match", m0, 0);
        check("miss_latency", l0, 8);
        check("miss_match_tol16", m16, 0);
        check("miss_colour_tol16", c16, 0);
        handoff();

        run(24'hF01010);
        check("near_red_colour", c0, NEAR ? 4 : 0);
        check("near_red_match", m0, 0);
        check("near_red_latency", l0, 8);
        check("tol16_red_colour", c16, 4);
        check("tol16_red_match", m16, 1);
        check("tol16_red_latency", l16, 5);
        handoff();

        run(24'hF00FF8);
        check("tol0_mag_match", m0, 0);
        check("tol0_mag_colour", c0, NEAR ? 5 : 0);
        check("tol16_mag_colour", c16, 5);
        check("tol16_mag_match", m16, 1);
        check("tol16_mag_latency", l16, 6);
        handoff();

        run(24'h00FF00);
        check("bp_latency", l0, 3);
        for (int i = 0; i < 5; i++) begin
            rgb_in = 24'h0000FF;
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("bp_result_valid", rv0, 1);
            check("bp_colour", c0, 2);
            check("bp_match", m0, 1);
            check("bp_req_ready", rr0, 0);
        end
        req_valid = 1'b0;
        handoff();
        @(negedge clk);
        check("bp_second_req_ignored", rv0, 0);
        run(24'h0000FF);
        check("post_bp_colour", c0, 1);
        check("post_bp_latency", l0, 2);
        handoff();

        @(negedge clk);
        rgb_in = 24'hFFFFFF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midscan_rst_result_valid", rv0, 0);
        check("midscan_rst_colour", c0, 0);
        check("midscan_rst_req_ready", rr0, 0);
        rst_n = 1'b1;
        #1;
        check("midscan_idle_req_ready", rr0, 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rv0) seen++;
        end
        check("midscan_no_result", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
